// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
// Each bit passes through two cascaded half-subtractors; the borrow between
// bits lives in a single flop. Start/busy/done handshake, WIDTH+1 clocks/op.

// Half-subtractor cell: d = x - y (one bit), bo = borrow out.
module serial_subtractor_hs (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);
    assign d  = x ^ y;
    assign bo = ~x & y;
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;      // minuend, shifted right each bit
    logic [WIDTH-1:0] sb;      // subtrahend, shifted right each bit
    logic [WIDTH-1:0] res;     // partial result, filled from the MSB side
    logic [CW-1:0]    count;   // index of the bit processed on the next edge
    logic             br;      // borrow carried between bits

    logic d1, b1, d, b2, bnext;

    // Stage 1 subtracts the operand bits, stage 2 subtracts the incoming borrow.
    serial_subtractor_hs u_stage1 (.x(sa[0]), .y(sb[0]), .d(d1), .bo(b1));
    serial_subtractor_hs u_stage2 (.x(d1),    .y(br),    .d(d),  .bo(b2));

    assign bnext = b1 | b2;

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            count  <= '0;
            br     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // start is deliberately ignored here; operands are already captured
                    sa    <= {1'b0, sa[WIDTH-1:1]};
                    sb    <= {1'b0, sb[WIDTH-1:1]};
                    res   <= {d, res[WIDTH-1:1]};
                    br    <= bnext;
                    if (count == LAST) begin
                        // last bit: publish result together with the final borrow
                        diff   <= {d, res[WIDTH-1:1]};
                        borrow <= bnext;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        count  <= '0;
                        state  <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor (WIDTH = 8).
// Reference: expected diff = (a - b) mod 256, borrow = (a < b).
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow;
    logic [W-1:0] diff;

    int vectors    = 0;
    int miscompares = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'(x) - int'(y);
        ref_sub = {(x < y), W'(r + 256)};
    endfunction

    // Single op with start pulsed for one cycle; optionally fires a stray
    // start (a=1, b=2) across edge k+inject while the op runs.
    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input int inject);
        logic [W:0]   exp;
        logic [W-1:0] held;
        int n, extra;
        exp = ref_sub(ai, bi);
        @(negedge clk);
        a = ai; b = bi; start = 1'b1;
        held = diff;
        @(posedge clk);
        #1 start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (done) break;
            chk("busy_run", busy, 1'b1);
            if (n == 4) chk("diff_hold", diff, held);
            if (n == inject - 1) begin a = 8'd1; b = 8'd2; start = 1'b1; end
            if (n == inject) start = 1'b0;
            a = (n == inject - 1) ? a : W'($urandom);
            n++;
        end
        chk("latency", n, W);
        chk("diff", diff, exp[W-1:0]);
        chk("borrow", borrow, exp[W]);
        chk("busy_end", busy, 1'b0);
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("one_done", extra, 0);
    endtask

    // start held high; a new pair is presented whenever the block is idle.
    task automatic stream(input int npairs, input logic [W-1:0] fa[3], input logic [W-1:0] fb[3]);
        logic [W:0] expq[$];
        logic [W:0] e;
        int idx, got, cyc, last_done;
        idx = 0; got = 0; cyc = 0; last_done = -1;
        while (got < npairs && cyc < npairs * (W + 1) + 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (expq.size() == 0) chk("stray_done", 1, 0);
                else begin
                    e = expq.pop_front();
                    chk("s_diff", diff, e[W-1:0]);
                    chk("s_borrow", borrow, e[W]);
                end
                if (last_done >= 0) chk("s_gap", cyc - last_done, W + 1);
                last_done = cyc;
                got++;
            end
            if (!busy) begin
                if (idx < npairs) begin
                    if (idx < 3) begin a = fa[idx]; b = fb[idx]; end
                    else begin a = W'($urandom); b = W'($urandom); end
                    expq.push_back(ref_sub(a, b));
                    start = 1'b1;
                    idx++;
                end else start = 1'b0;
            end else begin
                a = W'($urandom); b = W'($urandom);
            end
        end
        chk("s_count", got, npairs);
        start = 1'b0;
    endtask

    initial begin
        logic [W-1:0] fa[3];
        logic [W-1:0] fb[3];
        int extra;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_borrow", borrow, 1'b0);
        rst_n = 1'b1;

        do_op(8'd9,   8'd5,   -5);
        do_op(8'd5,   8'd9,   -5);
        do_op(8'd0,   8'd1,   -5);
        do_op(8'hFF,  8'hFF,  -5);
        do_op(8'hFF,  8'h00,  -5);
        do_op(8'h80,  8'h7F,  -5);
        do_op(8'd20,  8'd7,   3);

        // abort mid-operation with an asynchronous reset
        @(negedge clk);
        a = 8'd3; b = 8'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 1'b0);
        chk("ar_done", done, 1'b0);
        chk("ar_diff", diff, 8'h00);
        chk("ar_borrow", borrow, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("ar_no_done", extra, 0);
        do_op(8'd50, 8'd8, -5);

        fa[0] = 8'd10;  fb[0] = 8'd3;
        fa[1] = 8'd3;   fb[1] = 8'd10;
        fa[2] = 8'd200; fb[2] = 8'd100;
        stream(3, fa, fb);
        repeat (3) @(negedge clk);
        stream(1500, fa, fb);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
